title_overlay: RTL and testbench
================================

# title_overlay

Parametrised start/title-screen compositor for the 1024x768 (65 MHz) video path. It draws NUM_BOXES solid rectangles over the camera image. It runs a TITLE -> COUNTDOWN -> DONE sequence driven by a button pulse and frame ticks, and signals completion to the top-level game FSM. It replaces the fixed two-box start screen with runtime box geometry, a cancellable blinking countdown and an explicit handshake back to IDLE.

## Interface
- NUM_BOXES, 2: number of rectangles (1..8). Box 0 is the title box; boxes 1..N-1 are auxiliary.
- BOX_COLOR, 12'hFFF: RGB444 colour of all boxes.
- BLINK_FRAMES, 15: frames per half-period of the box-0 blink during countdown (>=1).
- COUNTDOWN_FRAMES, 180: frames spent in COUNTDOWN before DONE (>=1).
- H_ACTIVE, 1024 / V_ACTIVE, 768: active-area size.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- enable_in  in  1  title screen selected by the top-level FSM.
- sw_mode_in  in  1  1 = show auxiliary boxes 1..N-1.
- btn_in  in  1  single-cycle debounced press pulse.
- hcount_in  in  11  current pixel x.
- vcount_in  in  10  current pixel y.
- cam_pixel_in  in  12  camera pixel aligned with hcount_in/vcount_in.
- box_x_in / box_w_in  in  NUM_BOXES*11  packed per-box x and width; box i is at [i*11 +: 11].
- box_y_in / box_h_in  in  NUM_BOXES*10  packed per-box y and height; box i is at [i*10 +: 10].
- pixel_out  out  12  composited pixel.
- done_out  out  1  high while in DONE.
- state_out  out  2  IDLE=0, TITLE=1, COUNTDOWN=2, DONE=3.

## Operation
- Frame tick: one cycle where hcount_in==0 and vcount_in==0. All frame counting uses this tick.
- Hit test for box i: x <= hcount < x+w and y <= vcount < y+h.
  - Sums are computed one bit wider (12/11 bits), so boxes running past the screen edge never wrap.
  - w==0 or h==0 means the box is never hit.
- Box visibility:
  - Box 0 is visible in TITLE, and in COUNTDOWN only while blink_on==1.
  - Boxes 1..N-1 are visible only in TITLE and COUNTDOWN, and only when sw_mode_in==1.
- Pixel rule:
  - Outside the active area (hcount>=H_ACTIVE or vcount>=V_ACTIVE): 12'h000.
  - In IDLE and DONE: 12'h000.
  - Otherwise: the background (see Configuration), with BOX_COLOR applied if any visible box is hit.
- FSM:
  - IDLE -> TITLE when enable_in==1.
  - TITLE -> COUNTDOWN on btn_in. On entry, frame_cnt=0, blink_cnt=0 and blink_on=1.
  - COUNTDOWN:
    - Each frame tick: frame_cnt++. Also blink_cnt++; when blink_cnt reaches BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
    - frame_cnt==COUNTDOWN_FRAMES-1 on a tick -> DONE.
    - btn_in -> TITLE (cancel).
  - DONE: done_out=1 held. Leave to IDLE only when enable_in==0.
  - enable_in==0 in TITLE or COUNTDOWN -> IDLE immediately; counters clear.
- Simultaneous events:
  - Cancel beats completion: btn_in on the final tick goes to TITLE.
  - enable_in==0 beats btn_in.
  - btn_in in IDLE or DONE is ignored.
- Counter widths: $clog2(COUNTDOWN_FRAMES+1) and $clog2(BLINK_FRAMES+1).

## Timing
- pixel_out is registered, with a 1-cycle latency from hcount_in/vcount_in/cam_pixel_in.
- The box compare is single-stage combinational.
- State transitions take effect on the clock edge that samples the trigger. state_out and done_out are registered: visible the cycle after the trigger.
- pixel_out uses the state registered at the same edge as the pixel inputs, so a transition changes the image from the next pixel.
- Reset values:
  - state=IDLE, pixel_out=12'h000, done_out=0, state_out=0.
  - frame_cnt=0, blink_cnt=0, blink_on=1.
  - Reset mid-countdown aborts to IDLE in one cycle.

## Configuration
- TITLE_OVERLAY_CAM_EN defined: background = cam_pixel_in, and a hit box yields BOX_COLOR | cam_pixel_in (OR blend).
- TITLE_OVERLAY_CAM_EN undefined: cam_pixel_in is ignored, the background is 12'h000, and a hit box yields BOX_COLOR.

## Test plan
- Reset: hold rst 3 cycles -> pixel_out=000, done_out=0, state_out=0. Then enable_in=1 -> state_out=1 next cycle.
- TITLE with box0=(100,50,800,128), box1=(600,300,200,200), cam=12'h00F (CAM_EN):
  - sw_mode=0: pixel at (650,350) -> 00F; at (150,60) -> FFF.
  - sw_mode=1: pixel at (650,350) -> FFF.
  - Pixel at (1030,10) -> 000.
- Countdown (COUNTDOWN_FRAMES=4, BLINK_FRAMES=2): btn_in in TITLE -> state 2. Box 0 is hidden during frames 2-3. After the 4th tick -> state 3 and done_out=1. done_out stays high until enable_in=0, then IDLE.
- Cancel: btn_in coincident with the final frame tick -> state 1, done_out stays 0, counters cleared.
- enable_in=0 mid-countdown -> IDLE next cycle, pixel_out=000. Re-enable + btn -> full countdown restarts from 0.
- Edge box at x=1000, w=100: no hit at hcount 0..75 (no wrap); hit at 1000..1023.

Source files
------------

// File: rtl/title_overlay_if.sv
// title_overlay_if -- control and video bus of the title-screen compositor.
//   slave  : the compositor. It receives control, raster position, camera pixel
//            and box geometry. It drives pixel_out, done_out and state_out.
//   master : the driver of the compositor (top-level FSM / video path).
// Box geometry is packed per box: x/w at [i*11 +: 11], y/h at [i*10 +: 10].
interface title_overlay_if #(
    parameter int NUM_BOXES = 2
);
    logic                     enable_in;
    logic                     sw_mode_in;
    logic                     btn_in;
    logic [10:0]              hcount_in;
    logic [9:0]               vcount_in;
    logic [11:0]              cam_pixel_in;
    logic [NUM_BOXES*11-1:0]  box_x_in;
    logic [NUM_BOXES*11-1:0]  box_w_in;
    logic [NUM_BOXES*10-1:0]  box_y_in;
    logic [NUM_BOXES*10-1:0]  box_h_in;
    logic [11:0]              pixel_out;
    logic                     done_out;
    logic [1:0]               state_out;

    modport slave (
        input  enable_in, sw_mode_in, btn_in, hcount_in, vcount_in, cam_pixel_in,
               box_x_in, box_w_in, box_y_in, box_h_in,
        output pixel_out, done_out, state_out
    );

    modport master (
        output enable_in, sw_mode_in, btn_in, hcount_in, vcount_in, cam_pixel_in,
               box_x_in, box_w_in, box_y_in, box_h_in,
        input  pixel_out, done_out, state_out
    );
endinterface

// File: rtl/title_overlay.sv
// title_overlay -- start/title-screen compositor for the 1024x768 video path.
// The module draws NUM_BOXES solid rectangles over the image. It runs the
// sequence IDLE -> TITLE -> COUNTDOWN -> DONE. A button pulse advances or
// cancels the sequence. Frame ticks pace the countdown.
// Ports:
//   clk  pixel clock
//   rst  synchronous, active-high reset
//   bus  title_overlay_if.slave. Carries control (enable/sw_mode/btn), the
//        raster position, the camera pixel and the box geometry. Returns the
//        composited pixel (1-cycle latency), done_out and state_out.
// Build option: define TITLE_OVERLAY_CAM_EN to composite over cam_pixel_in
// (OR blend). Without it the background is black.
module title_overlay #(
    parameter int          NUM_BOXES        = 2,
    parameter logic [11:0] BOX_COLOR        = 12'hFFF,
    parameter int          BLINK_FRAMES     = 15,
    parameter int          COUNTDOWN_FRAMES = 180,
    parameter int          H_ACTIVE         = 1024,
    parameter int          V_ACTIVE         = 768
) (
    input logic           clk,
    input logic           rst,
    title_overlay_if.slave bus
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_TITLE     = 2'd1;
    localparam logic [1:0] S_COUNTDOWN = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    localparam int FW = $clog2(COUNTDOWN_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(COUNTDOWN_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [11:0]   H_LIM      = 12'(H_ACTIVE);
    localparam logic [10:0]   V_LIM      = 11'(V_ACTIVE);

    logic [1:0]    state_q, state_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic [11:0]   pixel_q, pixel_d;
    logic          done_q, done_d;

    logic frame_tick;
    logic outside;
    logic active_state;
    logic any_hit;
    logic [NUM_BOXES-1:0] hit;
    logic [NUM_BOXES-1:0] visible;

    assign frame_tick   = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
    assign outside      = ({1'b0, bus.hcount_in} >= H_LIM) || ({1'b0, bus.vcount_in} >= V_LIM);
    assign active_state = (state_q == S_TITLE) || (state_q == S_COUNTDOWN);

    // Each end coordinate is one bit wider than the position so that a box that
    // runs past the screen edge cannot wrap back onto the left/top. With w==0
    // or h==0 the range is empty and the box never hits.
    for (genvar i = 0; i < NUM_BOXES; i++) begin : g_box
        logic [11:0] x_end;
        logic [10:0] y_end;
        assign x_end  = {1'b0, bus.box_x_in[i*11 +: 11]} + {1'b0, bus.box_w_in[i*11 +: 11]};
        assign y_end  = {1'b0, bus.box_y_in[i*10 +: 10]} + {1'b0, bus.box_h_in[i*10 +: 10]};
        assign hit[i] = (bus.hcount_in >= bus.box_x_in[i*11 +: 11]) &&
                        ({1'b0, bus.hcount_in} < x_end) &&
                        (bus.vcount_in >= bus.box_y_in[i*10 +: 10]) &&
                        ({1'b0, bus.vcount_in} < y_end);
        if (i == 0) begin : g_title
            // The title box blinks only during the countdown.
            assign visible[i] = (state_q == S_TITLE) ||
                                ((state_q == S_COUNTDOWN) && blink_on_q);
        end else begin : g_aux
            assign visible[i] = active_state && bus.sw_mode_in;
        end
    end

    assign any_hit = |(hit & visible);

`ifdef TITLE_OVERLAY_CAM_EN
    always_comb begin
        pixel_d = 12'h000;
        if (!outside && active_state) begin
            pixel_d = any_hit ? (BOX_COLOR | bus.cam_pixel_in) : bus.cam_pixel_in;
        end
    end
`else
    logic unused_cam;
    assign unused_cam = ^bus.cam_pixel_in;

    always_comb begin
        pixel_d = 12'h000;
        if (!outside && active_state && any_hit) begin
            pixel_d = BOX_COLOR;
        end
    end
`endif

    // Counters hold only while the FSM stays in COUNTDOWN. Every other path
    // returns them to the entry values, so each countdown starts from zero.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = '0;
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (bus.enable_in) state_d = S_TITLE;
            end
            S_TITLE: begin
                if (!bus.enable_in)  state_d = S_IDLE;
                else if (bus.btn_in) state_d = S_COUNTDOWN;
            end
            S_COUNTDOWN: begin
                if (!bus.enable_in) begin
                    state_d = S_IDLE;
                end else if (bus.btn_in) begin
                    state_d = S_TITLE;      // a cancel wins over completion
                end else begin
                    frame_cnt_d = frame_cnt_q;
                    blink_cnt_d = blink_cnt_q;
                    blink_on_d  = blink_on_q;
                    if (frame_tick) begin
                        if (frame_cnt_q == FRAME_LAST) begin
                            state_d     = S_DONE;
                            frame_cnt_d = '0;
                            blink_cnt_d = '0;
                            blink_on_d  = 1'b1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FW'(1);
                            if (blink_cnt_q == BLINK_LAST) begin
                                blink_cnt_d = '0;
                                blink_on_d  = ~blink_on_q;
                            end else begin
                                blink_cnt_d = blink_cnt_q + BW'(1);
                            end
                        end
                    end
                end
            end
            default: begin            // S_DONE
                if (!bus.enable_in) state_d = S_IDLE;
            end
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            pixel_q     <= 12'h000;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            pixel_q     <= pixel_d;
            done_q      <= done_d;
        end
    end

    assign bus.pixel_out = pixel_q;
    assign bus.done_out  = done_q;
    assign bus.state_out = state_q;
endmodule

// File: tb/tb_title_overlay.sv
// tb_title_overlay -- scoreboard bench for title_overlay. It uses
// COUNTDOWN_FRAMES=4 and BLINK_FRAMES=2. The stimulus drives inputs #1 after
// a rising edge and queues the value expected after the next edge. A monitor
// checks that value at the following falling edge. Expected pixels follow the
// build: with TITLE_OVERLAY_CAM_EN the background is the camera pixel.
module tb_title_overlay;
    localparam int PIX = 0, ST = 1, DN = 2;
    localparam logic [11:0] CAM = 12'h00F;
`ifdef TITLE_OVERLAY_CAM_EN
    localparam logic [11:0] BG  = CAM;
    localparam logic [11:0] HIT = 12'hFFF | CAM;
`else
    localparam logic [11:0] BG  = 12'h000;
    localparam logic [11:0] HIT = 12'hFFF;
`endif

    typedef struct {
        int          cyc;
        string       name;
        int          kind;
        logic [11:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t sb[$];

    title_overlay_if #(.NUM_BOXES(2)) bus();

    title_overlay #(
        .NUM_BOXES(2), .BOX_COLOR(12'hFFF), .BLINK_FRAMES(2),
        .COUNTDOWN_FRAMES(4), .H_ACTIVE(1024), .V_ACTIVE(768)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every entry that falls due on this cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [11:0] got;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            case (e.kind)
                PIX:     got = bus.pixel_out;
                ST:      got = {10'b0, bus.state_out};
                default: got = {11'b0, bus.done_out};
            endcase
            if (e.cyc != cyc || got !== e.val) begin
                n_miss++;
                $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                         e.name, got, e.val, cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string nm, input int kind, input logic [11:0] v);
        exp_t e;
        e.cyc  = cyc + 1;
        e.name = nm;
        e.kind = kind;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic hv(input int h, input int v);
        bus.hcount_in = 11'(h);
        bus.vcount_in = 10'(v);
    endtask

    task automatic set_box1(input int x, input int y, input int w, input int h);
        bus.box_x_in[21:11] = 11'(x);
        bus.box_y_in[19:10] = 10'(y);
        bus.box_w_in[21:11] = 11'(w);
        bus.box_h_in[19:10] = 10'(h);
    endtask

    // A one-cycle frame tick (optionally with a button press). The next cycle
    // returns to (150,60), which lies inside box 0.
    task automatic tick(input string nm, input logic [1:0] st, input logic b);
        step();
        hv(0, 0);
        bus.btn_in = b;
        expect_val(nm, ST, {10'b0, st});
        step();
        hv(150, 60);
        bus.btn_in = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.enable_in = 1'b0;
        bus.sw_mode_in = 1'b0;
        bus.btn_in = 1'b0;
        bus.cam_pixel_in = CAM;
        bus.box_x_in[10:0] = 11'd100;
        bus.box_y_in[9:0]  = 10'd50;
        bus.box_w_in[10:0] = 11'd800;
        bus.box_h_in[9:0]  = 10'd128;
        set_box1(600, 300, 200, 200);
        hv(5, 5);

        // Reset
        repeat (3) step();
        expect_val("rst_pixel", PIX, 12'h000);
        expect_val("rst_state", ST, 12'd0);
        expect_val("rst_done", DN, 12'd0);
        step(); rst = 1'b0; bus.enable_in = 1'b1; expect_val("enable_title", ST, 12'd1);

        // TITLE compositing
        step(); hv(650, 350); expect_val("sw0_box1_hidden", PIX, BG);
        step(); hv(150, 60);  expect_val("box0_hit", PIX, HIT);
        step(); bus.sw_mode_in = 1'b1; hv(650, 350); expect_val("sw1_box1_hit", PIX, HIT);
        step(); hv(900, 600); expect_val("sw1_miss", PIX, BG);
        step(); hv(1030, 10); expect_val("offscreen", PIX, 12'h000);

        // Edge box: must not wrap onto the left side
        step(); set_box1(1000, 0, 100, 768); hv(50, 100); expect_val("edge_h50", PIX, BG);
        step(); hv(75, 100);   expect_val("edge_h75", PIX, BG);
        step(); hv(999, 100);  expect_val("edge_h999", PIX, BG);
        step(); hv(1000, 100); expect_val("edge_h1000", PIX, HIT);
        step(); hv(1023, 100); expect_val("edge_h1023", PIX, HIT);
        step(); set_box1(1000, 0, 0, 768); hv(1010, 100); expect_val("w0_no_hit", PIX, BG);
        step(); set_box1(600, 300, 200, 200); bus.sw_mode_in = 1'b0; hv(150, 60);
        expect_val("title_hold", ST, 12'd1);

        // Full countdown. Box 0 is hidden after tick 2.
        step(); bus.btn_in = 1'b1; expect_val("btn_countdown", ST, 12'd2);
        step(); bus.btn_in = 1'b0; expect_val("cd_entry_vis", PIX, HIT);
        tick("t1_state", 2'd2, 1'b0); expect_val("t1_vis", PIX, HIT);
        tick("t2_state", 2'd2, 1'b0); expect_val("t2_hidden", PIX, BG);
        tick("t3_state", 2'd2, 1'b0); expect_val("t3_hidden", PIX, BG);
        tick("t4_state", 2'd3, 1'b0); expect_val("t4_done", DN, 12'd1);
        step(); expect_val("done_pixel", PIX, 12'h000);
        step(); bus.btn_in = 1'b1; expect_val("done_btn_ignored", ST, 12'd3);
        step(); bus.btn_in = 1'b0; expect_val("done_held", DN, 12'd1);
        step(); bus.enable_in = 1'b0; expect_val("done_exit", ST, 12'd0);
        expect_val("done_clear", DN, 12'd0);
        step(); bus.btn_in = 1'b1; expect_val("idle_btn_ignored", ST, 12'd0);

        // Cancel on the final tick, then confirm the counters restarted.
        step(); bus.btn_in = 1'b0; bus.enable_in = 1'b1; expect_val("reenable", ST, 12'd1);
        step(); bus.btn_in = 1'b1; expect_val("cancel_start", ST, 12'd2);
        step(); bus.btn_in = 1'b0;
        tick("c_t1", 2'd2, 1'b0);
        tick("c_t2", 2'd2, 1'b0);
        tick("c_t3", 2'd2, 1'b0);
        tick("cancel_final", 2'd1, 1'b1); expect_val("cancel_no_done", DN, 12'd0);
        step(); bus.btn_in = 1'b1; expect_val("restart", ST, 12'd2);
        step(); bus.btn_in = 1'b0;
        tick("r_t1", 2'd2, 1'b0);
        tick("r_t2", 2'd2, 1'b0);
        tick("r_t3_not_done", 2'd2, 1'b0);
        tick("r_t4_done", 2'd3, 1'b0);

        // Disable mid-countdown. enable_in low wins over btn_in.
        step(); bus.enable_in = 1'b0; expect_val("r_exit", ST, 12'd0);
        step(); bus.enable_in = 1'b1; expect_val("m_title", ST, 12'd1);
        step(); bus.btn_in = 1'b1; expect_val("m_countdown", ST, 12'd2);
        step(); bus.btn_in = 1'b0;
        tick("m_t1", 2'd2, 1'b0);
        tick("m_t2", 2'd2, 1'b0);
        step(); bus.enable_in = 1'b0; bus.btn_in = 1'b1; expect_val("abort_idle", ST, 12'd0);
        step(); bus.btn_in = 1'b0; expect_val("abort_pixel", PIX, 12'h000);
        step(); bus.enable_in = 1'b1; expect_val("a_title", ST, 12'd1);
        step(); bus.btn_in = 1'b1; expect_val("a_countdown", ST, 12'd2);
        step(); bus.btn_in = 1'b0;
        tick("a_t1", 2'd2, 1'b0);
        tick("a_t2", 2'd2, 1'b0);
        tick("a_t3_not_done", 2'd2, 1'b0);
        tick("a_t4_done", 2'd3, 1'b0);

        // Reset in the middle of a countdown
        step(); bus.enable_in = 1'b0; expect_val("b_idle", ST, 12'd0);
        step(); bus.enable_in = 1'b1; expect_val("b_title", ST, 12'd1);
        step(); bus.btn_in = 1'b1; expect_val("b_countdown", ST, 12'd2);
        step(); bus.btn_in = 1'b0;
        tick("b_t1", 2'd2, 1'b0);
        step(); rst = 1'b1; expect_val("rst_mid_state", ST, 12'd0);
        expect_val("rst_mid_pixel", PIX, 12'h000);
        step(); rst = 1'b0;

        repeat (3) step();
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
